// File: rtl/pic_exec_writeback.sv
// pic_exec_writeback
//   Execute/writeback stage that sits directly behind the PIC16C57 ALU.
//   It runs the Q1..Q4 instruction cycle:
//     Q1 - latch the decoded instruction (or a NOP when squashing or idle)
//     Q2 - idle while the ALU operands settle
//     Q3 - register the ALU result and flags
//     Q4 - commit to W, to the file write port and to STATUS,
//          and evaluate conditional skips
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   instr_valid        decoded instruction present; sampled at Q1
//   wb_dest            0 = write W, 1 = write file register
//   wb_en              instruction produces a result
//   f_addr_in          file register address of the instruction
//   upd_z/upd_dc/upd_c instruction affects Z / DC / C
//   skip_mode          00 none, 01 skip if test, 10 skip if !test, 11 skip if z
//   alu_out, alu_*     ALU result and flags; sampled at Q3
//   q_phase            current phase (0=Q1 .. 3=Q4)
//   w_reg              working register
//   f_we/f_addr/f_wdata file write port; f_we is a one-clock pulse at Q4
//   status             STATUS register (bit0=C, bit1=DC, bit2=Z)
//   alu_cin            carry fed back to the ALU (status[0])
//   squashed           one-clock pulse at Q4 of a squashed instruction

module pic_exec_writeback #(
  parameter logic [4:0] STATUS_ADDR = 5'd3,
  parameter logic [7:0] STATUS_RST  = 8'h18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic       wb_dest,
  input  logic       wb_en,
  input  logic [4:0] f_addr_in,
  input  logic       upd_z,
  input  logic       upd_dc,
  input  logic       upd_c,
  input  logic [1:0] skip_mode,
  input  logic [7:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_dc,
  input  logic       alu_cout,
  input  logic       alu_test,
  output logic [1:0] q_phase,
  output logic [7:0] w_reg,
  output logic       f_we,
  output logic [4:0] f_addr,
  output logic [7:0] f_wdata,
  output logic [7:0] status,
  output logic       alu_cin,
  output logic       squashed
);

  // Phase counter
  logic [1:0] r_phase;

  // Instruction fields latched at Q1
  logic       r_dest;
  logic       r_en;
  logic [4:0] r_addr;
  logic       r_uz;
  logic       r_udc;
  logic       r_uc;
  logic [1:0] r_skip_mode;
  logic       r_kill;
  logic       r_skip_pending;

  // ALU values registered at Q3
  logic [7:0] r_res;
  logic       r_z;
  logic       r_dc;
  logic       r_c;
  logic       r_test;

  // Architectural state and output registers
  logic [7:0] r_w;
  logic [7:0] r_status;
  logic       r_f_we;
  logic [4:0] r_f_addr;
  logic [7:0] r_f_wdata;
  logic       r_squashed;

  logic       w_q1;
  logic       w_q3;
  logic       w_q4;
  logic       w_file_wr;
  logic       w_w_wr;
  logic       w_skip_hit;
  logic [7:0] w_status_next;

  assign w_q1 = (r_phase == 2'd0);
  assign w_q3 = (r_phase == 2'd2);
  assign w_q4 = (r_phase == 2'd3);

  // A killed slot already holds a NOP; the explicit kill gating keeps a
  // squashed instruction inert even if the NOP encoding changes later.
  assign w_file_wr = r_en &  r_dest & ~r_kill;
  assign w_w_wr    = r_en & ~r_dest & ~r_kill;

  // A squashed skip instruction must never chain another skip.
  assign w_skip_hit = ~r_kill &
                      (((r_skip_mode == 2'b01) &  r_test) |
                       ((r_skip_mode == 2'b10) & ~r_test) |
                       ((r_skip_mode == 2'b11) &  r_z));

  // STATUS as a write destination takes the result first; any flag the
  // instruction updates then overrides the corresponding low bit.
  always_comb begin
    w_status_next = r_status;
    if (!r_kill) begin
      if (w_file_wr && (r_addr == STATUS_ADDR)) begin
        w_status_next = r_res;
      end
      if (r_uc) begin
        w_status_next[0] = r_c;
      end
      if (r_udc) begin
        w_status_next[1] = r_dc;
      end
      if (r_uz) begin
        w_status_next[2] = r_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase        <= 2'd0;
      r_dest         <= 1'b0;
      r_en           <= 1'b0;
      r_addr         <= 5'd0;
      r_uz           <= 1'b0;
      r_udc          <= 1'b0;
      r_uc           <= 1'b0;
      r_skip_mode    <= 2'b00;
      r_kill         <= 1'b0;
      r_skip_pending <= 1'b0;
      r_res          <= 8'h00;
      r_z            <= 1'b0;
      r_dc           <= 1'b0;
      r_c            <= 1'b0;
      r_test         <= 1'b0;
      r_w            <= 8'h00;
      r_status       <= STATUS_RST;
      r_f_we         <= 1'b0;
      r_f_addr       <= 5'd0;
      r_f_wdata      <= 8'h00;
      r_squashed     <= 1'b0;
    end else begin
      r_phase <= r_phase + 2'd1;

      // Strobes are set on the edge entering Q4 so they are high only
      // while q_phase reads 3, and low in every other phase.
      r_f_we     <= 1'b0;
      r_squashed <= 1'b0;

      if (w_q1) begin
        r_kill         <= r_skip_pending;
        r_skip_pending <= 1'b0;
        if (instr_valid && !r_skip_pending) begin
          r_dest      <= wb_dest;
          r_en        <= wb_en;
          r_addr      <= f_addr_in;
          r_uz        <= upd_z;
          r_udc       <= upd_dc;
          r_uc        <= upd_c;
          r_skip_mode <= skip_mode;
        end else begin
          r_dest      <= 1'b0;
          r_en        <= 1'b0;
          r_addr      <= 5'd0;
          r_uz        <= 1'b0;
          r_udc       <= 1'b0;
          r_uc        <= 1'b0;
          r_skip_mode <= 2'b00;
        end
      end

      if (w_q3) begin
        r_res      <= alu_out;
        r_z        <= alu_z;
        r_dc       <= alu_dc;
        r_c        <= alu_cout;
        r_test     <= alu_test;
        r_squashed <= r_kill;
        // The file port carries exactly the value registered here, so it
        // is presented during Q4 and then held until the next write.
        if (w_file_wr) begin
          r_f_we    <= 1'b1;
          r_f_addr  <= r_addr;
          r_f_wdata <= alu_out;
        end
      end

      if (w_q4) begin
        if (w_w_wr) begin
          r_w <= r_res;
        end
        r_status       <= w_status_next;
        r_skip_pending <= w_skip_hit;
      end
    end
  end

  assign q_phase  = r_phase;
  assign w_reg    = r_w;
  assign f_we     = r_f_we;
  assign f_addr   = r_f_addr;
  assign f_wdata  = r_f_wdata;
  assign status   = r_status;
  assign alu_cin  = r_status[0];
  assign squashed = r_squashed;

endmodule
